mmc1_serial_mapper: RTL and testbench
=====================================

// Module: mmc1_serial_mapper
// PURPOSE
// Clocked, parametrised MMC1-class mapper for the cartridge CPLD/FPGA. It oversamples the CPU bus
// (M2, /ROMSEL, R/W, A14/A13, D7/D0) on a local oscillator and decodes 5-bit serial writes into
// the control, CHR0, CHR1 and PRG registers. It drives PRG/CHR bank lines, CIRAM_A10, /PRG_CE and
// WRAM_CE. New versus the previous mapper: parametric bank widths, a consecutive-write filter,
// a WRAM-disable bit, and a defined reset.
// PARAMETERS
// PRG_BANK_W   4  16KB PRG bank bits -> PRG_A[13+PRG_BANK_W:14]
// CHR_BANK_W   5  4KB CHR bank bits  -> CHR_A[11+CHR_BANK_W:12]
// SYNC_STAGES  2  synchroniser depth on all bus inputs (>=2)
// PORTS
// CLK          in   1  local clock, >=4x M2 frequency; only clock
// RST          in   1  synchronous, active-high reset
// CPU_M2       in   1  CPU phi2
// nCPU_ROMSEL  in   1  low = CPU $8000-$FFFF while M2 high
// nCPU_RW      in   1  low = CPU write
// CPU_A14, CPU_A13, CPU_D7, CPU_D0  in  1 each
// PPU_A12, PPU_A11, PPU_A10  in  1 each
// CIRAM_A10    out  1  nametable select
// PRG_A        out  PRG_BANK_W  PRG ROM A[13+PRG_BANK_W:14]
// nPRG_CE      out  1  PRG ROM chip enable, active low
// WRAM_CE      out  1  WRAM enable, active high
// CHR_A        out  CHR_BANK_W  CHR A[11+CHR_BANK_W:12]
// BEHAVIOUR
// - RST: shift=5'b10000, ctrl=5'b01100, chr0=chr1=prg=0, consec flag=0, sync pipes=0.
// - Bus inputs pass a SYNC_STAGES flop chain. A14/A13/D7/D0/RW/ROMSEL are latched each CLK while
//   synced M2=1. An M2 fall (synced 1->0) consumes the last latched set.
// - ROM write cycle = latched ROMSEL=0 and RW=0 at the M2 fall.
// - Consecutive filter: if the previous M2 cycle was also a ROM write, ignore the write completely
//   (no shift, no D7 reset). The flag updates on every M2 fall: 1 for a ROM write, else 0.
// - Accepted write with D7=1: shift<=5'b10000, ctrl<=ctrl|5'b01100. Other bits and registers unchanged.
// - Accepted write with D7=0:
//   - If shift[0]=0: shift<={D0,shift[4:1]}.
//   - If shift[0]=1 (5th write): value={D0,shift[4:1]}. A14:A13 selects the target:
//     00 ctrl, 01 chr0, 10 chr1, 11 prg. Then shift<=5'b10000.
// - Latency: register visible on the 1st CLK edge after the fall is detected.
//   That is SYNC_STAGES+1 CLK after the pin edge.
// - Outputs are combinational from registers plus raw (unsynchronised) live address pins.
//   Address paths have no CLK latency.
// - Mirroring ctrl[1:0]: 00 -> 0, 01 -> 1, 10 -> PPU_A10, 11 -> PPU_A11.
// - PRG modes, ctrl[3:2]:
//   - 0x: 32KB, PRG_A={prg[W-1:1],CPU_A14}.
//   - 10: A14=0 -> 0, A14=1 -> prg[W-1:0].
//   - 11: A14=0 -> prg[W-1:0], A14=1 -> all ones.
// - CHR ctrl[4]:
//   - 0 (8KB): CHR_A={chr0[W-1:1],PPU_A12}.
//   - 1 (4KB): PPU_A12 ? chr1[W-1:0] : chr0[W-1:0].
//   - Bank bits above W are ignored.
// - nPRG_CE = nCPU_ROMSEL | ~nCPU_RW (ROM is never enabled on writes).
// - WRAM_CE = CPU_M2 & nCPU_ROMSEL & CPU_A14 & CPU_A13 & ~prg[4]. prg[4]=1 disables WRAM.
// - RST mid-sequence discards the partial shift. An M2 fall in the same CLK as RST is ignored.
// STRUCTURE
// - Package mmc1_pkg: CTRL_RST=5'b01100, SHIFT_EMPTY=5'b10000, mirroring enum (ONE_LO, ONE_HI,
//   VERT, HORZ), PRG mode enum (PRG32, FIX_FIRST, FIX_LAST), register-select enum.
// - Sub-module mmc1_bus_sampler: synchronisers, data latch, M2 fall strobe and latched bus.
//   Shift/decode and output muxing stay in the top.
// TESTING
// 1. RST, then read $C000 and $8000 -> PRG_A=4'hF then 4'h0; CIRAM_A10=0; WRAM_CE=1 at $6000 with M2 high.
// 2. Five non-adjacent writes to $E000, D0=1,0,1,0,0 -> prg=5'b00101; read $8000 -> PRG_A=4'h5.
// 3. Three writes to $8000, then D7=1, then five writes D0=1,0,0,1,0 ($A000)
//    -> ctrl[3:2]=11 after D7; chr0=5'b01001.
// 4. Two back-to-back M2 cycles writing $E000 D0=1 -> only the first shifts; a third write after one
//    idle M2 cycle shifts again.
// 5. ctrl=5'b10010, chr0=3, chr1=7 -> PPU_A12=0 gives CHR_A=3, PPU_A12=1 gives CHR_A=7; CIRAM_A10 follows PPU_A10.
// 6. prg=5'b10000 -> WRAM_CE stays 0 on a $6000 access. RST after 2 shift writes -> next 5 writes load cleanly.

Source files
------------

// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1-class serial mapper.
// Register reset values, bus sample record and the mode/select decodes.
package mmc1_pkg;

  localparam logic [4:0] CTRL_RST    = 5'b01100;
  localparam logic [4:0] SHIFT_EMPTY = 5'b10000;

  typedef enum logic [1:0] {
    ONE_LO = 2'b00,
    ONE_HI = 2'b01,
    VERT   = 2'b10,
    HORZ   = 2'b11
  } mirror_e;

  typedef enum logic [1:0] {
    PRG32     = 2'b00,
    FIX_FIRST = 2'b10,
    FIX_LAST  = 2'b11
  } prg_mode_e;

  typedef enum logic [1:0] {
    SEL_CTRL = 2'b00,
    SEL_CHR0 = 2'b01,
    SEL_CHR1 = 2'b10,
    SEL_PRG  = 2'b11
  } reg_sel_e;

  // CPU bus fields captured during M2 high (M2 itself is tracked separately).
  typedef struct packed {
    logic romsel_n;
    logic rw_n;
    logic a14;
    logic a13;
    logic d7;
    logic d0;
  } bus_t;

  localparam int BUS_W = $bits(bus_t);

  localparam bus_t BUS_IDLE = '{romsel_n: 1'b1, rw_n: 1'b1, a14: 1'b0,
                                a13: 1'b0, d7: 1'b0, d0: 1'b0};

  // ctrl[3:2] = 0x both mean 32KB switching.
  function automatic prg_mode_e prg_mode(input logic [1:0] bits);
    return bits[1] ? prg_mode_e'(bits) : PRG32;
  endfunction

endpackage

// File: rtl/mmc1_bus_sampler.sv
// Synchronises the CPU bus into the local clock domain, holds the last bus
// set seen while M2 was high and strobes one cycle when synced M2 falls.
module mmc1_bus_sampler
  import mmc1_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_m2,
  input  logic [BUS_W-1:0] i_bus,
  output logic [BUS_W-1:0] o_lat,
  output logic             o_fall
);

  logic [SYNC_STAGES-1:0] r_m2_sync;
  bus_t                   r_bus_sync [SYNC_STAGES];
  bus_t                   r_lat;
  logic                   r_m2_prev;
  logic                   w_m2_s;
  bus_t                   w_bus_s;

  assign w_m2_s  = r_m2_sync[SYNC_STAGES-1];
  assign w_bus_s = r_bus_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m2_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_bus_sync[i] <= '0;
      r_lat     <= BUS_IDLE;
      r_m2_prev <= 1'b0;
    end else begin
      r_m2_sync     <= {r_m2_sync[SYNC_STAGES-2:0], i_m2};
      r_bus_sync[0] <= bus_t'(i_bus);
      for (int i = 1; i < SYNC_STAGES; i++) r_bus_sync[i] <= r_bus_sync[i-1];
      r_m2_prev <= w_m2_s;
      if (w_m2_s) r_lat <= w_bus_s;
    end
  end

  // On the fall cycle the latch still holds the final M2-high sample.
  assign o_fall = r_m2_prev & ~w_m2_s;
  assign o_lat  = r_lat;

endmodule

// File: rtl/mmc1_serial_mapper.sv
// MMC1-class mapper: 5-bit serial register loads from sampled CPU writes,
// with combinational PRG/CHR banking, mirroring and WRAM/ROM enables.
module mmc1_serial_mapper
  import mmc1_pkg::*;
#(
  parameter int PRG_BANK_W  = 4,
  parameter int CHR_BANK_W  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CPU_M2,
  input  logic                  nCPU_ROMSEL,
  input  logic                  nCPU_RW,
  input  logic                  CPU_A14,
  input  logic                  CPU_A13,
  input  logic                  CPU_D7,
  input  logic                  CPU_D0,
  input  logic                  PPU_A12,
  input  logic                  PPU_A11,
  input  logic                  PPU_A10,
  output logic                  CIRAM_A10,
  output logic [PRG_BANK_W-1:0] PRG_A,
  output logic                  nPRG_CE,
  output logic                  WRAM_CE,
  output logic [CHR_BANK_W-1:0] CHR_A
);

  logic [BUS_W-1:0] w_lat_raw;
  bus_t             w_lat;
  logic             w_fall;

  mmc1_bus_sampler #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_m2   (CPU_M2),
    .i_bus  ({nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D7, CPU_D0}),
    .o_lat  (w_lat_raw),
    .o_fall (w_fall)
  );

  assign w_lat = bus_t'(w_lat_raw);

  logic [4:0] r_shift;
  logic [4:0] r_ctrl;
  logic [4:0] r_chr0;
  logic [4:0] r_chr1;
  logic [4:0] r_prg;
  logic       r_consec;

  logic       w_rom_wr;
  logic       w_accept;
  logic [4:0] w_value;
  reg_sel_e   w_sel;

  assign w_rom_wr = w_fall & ~w_lat.romsel_n & ~w_lat.rw_n;
  // A ROM write directly after another ROM write is the second half of an RMW.
  assign w_accept = w_rom_wr & ~r_consec;
  assign w_value  = {w_lat.d0, r_shift[4:1]};
  assign w_sel    = reg_sel_e'({w_lat.a14, w_lat.a13});

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shift  <= SHIFT_EMPTY;
      r_ctrl   <= CTRL_RST;
      r_chr0   <= '0;
      r_chr1   <= '0;
      r_prg    <= '0;
      r_consec <= 1'b0;
    end else begin
      if (w_fall) r_consec <= w_rom_wr;
      if (w_accept) begin
        if (w_lat.d7) begin
          r_shift <= SHIFT_EMPTY;
          r_ctrl  <= r_ctrl | CTRL_RST;
        end else if (!r_shift[0]) begin
          r_shift <= w_value;
        end else begin
          // Marker bit reached bit 0: this is the fifth write.
          r_shift <= SHIFT_EMPTY;
          case (w_sel)
            SEL_CTRL: r_ctrl <= w_value;
            SEL_CHR0: r_chr0 <= w_value;
            SEL_CHR1: r_chr1 <= w_value;
            SEL_PRG:  r_prg  <= w_value;
            default:  r_prg  <= w_value;
          endcase
        end
      end
    end
  end

  mirror_e                 w_mirror;
  prg_mode_e               w_prg_mode;
  logic [PRG_BANK_W-1:0]   w_prg_bank;
  logic [CHR_BANK_W-1:0]   w_chr0_bank;
  logic [CHR_BANK_W-1:0]   w_chr1_bank;

  assign w_mirror    = mirror_e'(r_ctrl[1:0]);
  assign w_prg_mode  = prg_mode(r_ctrl[3:2]);
  assign w_prg_bank  = r_prg[PRG_BANK_W-1:0];
  assign w_chr0_bank = r_chr0[CHR_BANK_W-1:0];
  assign w_chr1_bank = r_chr1[CHR_BANK_W-1:0];

  always_comb begin
    CIRAM_A10 = 1'b0;
    case (w_mirror)
      ONE_LO:  CIRAM_A10 = 1'b0;
      ONE_HI:  CIRAM_A10 = 1'b1;
      VERT:    CIRAM_A10 = PPU_A10;
      HORZ:    CIRAM_A10 = PPU_A11;
      default: CIRAM_A10 = 1'b0;
    endcase
  end

  always_comb begin
    PRG_A = w_prg_bank;
    case (w_prg_mode)
      PRG32:     PRG_A[0] = CPU_A14;
      FIX_FIRST: PRG_A = CPU_A14 ? w_prg_bank : '0;
      FIX_LAST:  PRG_A = CPU_A14 ? '1 : w_prg_bank;
      default:   PRG_A = w_prg_bank;
    endcase
  end

  always_comb begin
    CHR_A = w_chr0_bank;
    if (!r_ctrl[4]) CHR_A[0] = PPU_A12;
    else            CHR_A = PPU_A12 ? w_chr1_bank : w_chr0_bank;
  end

  assign nPRG_CE = nCPU_ROMSEL | ~nCPU_RW;
  assign WRAM_CE = CPU_M2 & nCPU_ROMSEL & CPU_A14 & CPU_A13 & ~r_prg[4];

endmodule

// File: tb/tb_mmc1_serial_mapper.sv
// Directed and randomised CPU bus cycles against a register-level model of
// the mapper; outputs are compared at M2 high and after each M2 fall settles.
module tb_mmc1_serial_mapper;

  localparam int PW = 4;
  localparam int CW = 5;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_m2 = 1'b0, n_romsel = 1'b1, n_rw = 1'b1;
  logic cpu_a14 = 1'b0, cpu_a13 = 1'b0, cpu_d7 = 1'b0, cpu_d0 = 1'b0;
  logic ppu_a12 = 1'b0, ppu_a11 = 1'b0, ppu_a10 = 1'b0;
  logic ciram_a10, nprg_ce, wram_ce;
  logic [PW-1:0] prg_a;
  logic [CW-1:0] chr_a;

  always #5 clk = ~clk;

  mmc1_serial_mapper #(.PRG_BANK_W(PW), .CHR_BANK_W(CW), .SYNC_STAGES(SS)) dut (
    .CLK(clk), .RST(rst), .CPU_M2(cpu_m2), .nCPU_ROMSEL(n_romsel), .nCPU_RW(n_rw),
    .CPU_A14(cpu_a14), .CPU_A13(cpu_a13), .CPU_D7(cpu_d7), .CPU_D0(cpu_d0),
    .PPU_A12(ppu_a12), .PPU_A11(ppu_a11), .PPU_A10(ppu_a10),
    .CIRAM_A10(ciram_a10), .PRG_A(prg_a), .nPRG_CE(nprg_ce), .WRAM_CE(wram_ce),
    .CHR_A(chr_a)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: registers as integers, serial load as bit count + accumulator.
  int m_ctrl, m_chr0, m_chr1, m_prg, m_cnt, m_acc;
  bit m_last_wr;

  task automatic model_reset();
    m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
    m_cnt = 0; m_acc = 0; m_last_wr = 1'b0;
  endtask

  task automatic model_cycle(input logic rs, input logic rw, input logic a14,
                             input logic a13, input logic d7, input logic d0);
    bit wr;
    wr = (rs == 1'b0) && (rw == 1'b0);
    if (wr && !m_last_wr) begin
      if (d7) begin
        m_cnt = 0; m_acc = 0; m_ctrl = m_ctrl | 12;
      end else begin
        m_acc = m_acc + (int'(d0) << m_cnt);
        m_cnt = m_cnt + 1;
        if (m_cnt == 5) begin
          case ({a14, a13})
            2'b00:   m_ctrl = m_acc;
            2'b01:   m_chr0 = m_acc;
            2'b10:   m_chr1 = m_acc;
            default: m_prg  = m_acc;
          endcase
          m_cnt = 0; m_acc = 0;
        end
      end
    end
    m_last_wr = wr;
  endtask

  function automatic logic [7:0] exp_ciram();
    case (m_ctrl % 4)
      0:       return 8'd0;
      1:       return 8'd1;
      2:       return 8'(ppu_a10);
      default: return 8'(ppu_a11);
    endcase
  endfunction

  function automatic logic [7:0] exp_prg();
    int mask, bank, mode, a, r;
    mask = (1 << PW) - 1;
    bank = m_prg & mask;
    mode = (m_ctrl / 4) % 4;
    a    = int'(cpu_a14);
    if (mode < 2)       r = (bank & ~1) | a;
    else if (mode == 2) r = (a != 0) ? bank : 0;
    else                r = (a != 0) ? mask : bank;
    return 8'(r);
  endfunction

  function automatic logic [7:0] exp_chr();
    int mask, r;
    mask = (1 << CW) - 1;
    if (((m_ctrl / 16) % 2) == 0) r = (m_chr0 & mask & ~1) | int'(ppu_a12);
    else r = ppu_a12 ? (m_chr1 & mask) : (m_chr0 & mask);
    return 8'(r);
  endfunction

  function automatic logic [7:0] exp_nce();
    return (n_romsel == 1'b1 || n_rw == 1'b0) ? 8'd1 : 8'd0;
  endfunction

  function automatic logic [7:0] exp_wram();
    return (cpu_m2 && n_romsel && cpu_a14 && cpu_a13 && ((m_prg / 16) % 2 == 0)) ? 8'd1 : 8'd0;
  endfunction

  task automatic expect_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    ppu_a10 = 1'($urandom_range(0, 1));
    ppu_a11 = 1'($urandom_range(0, 1));
    ppu_a12 = 1'($urandom_range(0, 1));
    #1;
    expect_eq({tag, ":ciram"}, 8'(ciram_a10), exp_ciram());
    expect_eq({tag, ":prg_a"}, 8'(prg_a), exp_prg());
    expect_eq({tag, ":chr_a"}, 8'(chr_a), exp_chr());
    expect_eq({tag, ":nprg_ce"}, 8'(nprg_ce), exp_nce());
    expect_eq({tag, ":wram_ce"}, 8'(wram_ce), exp_wram());
  endtask

  // mode 0: normal, 1: time the register update, 2: RST on the fall-detect cycle
  task automatic bus_cycle(input logic rs, input logic rw, input logic a14, input logic a13,
                           input logic d7, input logic d0, input int hi, input int mode);
    @(negedge clk);
    cpu_a14 = a14; cpu_a13 = a13; cpu_d7 = d7; cpu_d0 = d0;
    n_rw = rw; n_romsel = 1'b1; cpu_m2 = 1'b0;
    @(negedge clk);
    cpu_m2 = 1'b1; n_romsel = rs;
    check_all("m2hi");
    repeat (hi) @(negedge clk);
    cpu_m2 = 1'b0; n_romsel = 1'b1;
    if (mode == 1) begin
      ppu_a10 = 1'b0; ppu_a11 = 1'b1;
      repeat (SS) @(posedge clk);
      #1 expect_eq("latency_before", 8'(ciram_a10), exp_ciram());
      model_cycle(rs, rw, a14, a13, d7, d0);
      @(posedge clk);
      #1 expect_eq("latency_after", 8'(ciram_a10), exp_ciram());
      repeat (2) @(negedge clk);
    end else if (mode == 2) begin
      repeat (SS) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
    end else begin
      repeat (SS + 2) @(negedge clk);
      model_cycle(rs, rw, a14, a13, d7, d0);
    end
    check_all("m2lo");
  endtask

  task automatic gap();
    bus_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
  endtask

  task automatic write_val(input logic a14, input logic a13, input int v, input int last_mode);
    for (int i = 0; i < 5; i++) begin
      bus_cycle(1'b0, 1'b0, a14, a13, 1'b0, 1'((v >> i) & 1), 3, (i == 4) ? last_mode : 0);
      gap();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cpu_m2 = 1'b0; n_romsel = 1'b1; n_rw = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wram_probe(input string tag, input logic [7:0] exp);
    @(negedge clk);
    n_romsel = 1'b1; n_rw = 1'b1; cpu_a14 = 1'b1; cpu_a13 = 1'b1; cpu_m2 = 1'b1;
    #1 expect_eq(tag, 8'(wram_ce), exp);
    repeat (3) @(negedge clk);
    cpu_m2 = 1'b0;
    repeat (SS + 2) @(negedge clk);
    model_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Reset state: fixed-last PRG mode, single-screen low mirroring, WRAM enabled.
    cpu_a14 = 1'b1; #1 expect_eq("rst_prg_c000", 8'(prg_a), 8'h0F);
    cpu_a14 = 1'b0; #1 expect_eq("rst_prg_8000", 8'(prg_a), 8'h00);
    expect_eq("rst_ciram", 8'(ciram_a10), 8'h00);
    wram_probe("rst_wram_6000", 8'h01);

    write_val(1'b1, 1'b1, 5'b00101, 0);
    @(negedge clk); cpu_a14 = 1'b0;
    #1 expect_eq("prg5_8000", 8'(prg_a), 8'h05);

    // Partial shift abandoned by a D7 write, then a clean CHR0 load.
    for (int i = 0; i < 3; i++) begin
      bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0);
      gap();
    end
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0);
    gap();
    @(negedge clk); cpu_a14 = 1'b1;
    #1 expect_eq("d7_fixlast", 8'(prg_a), 8'h0F);
    write_val(1'b0, 1'b1, 5'b01001, 0);
    @(negedge clk); ppu_a12 = 1'b0;
    #1 expect_eq("chr0_lo", 8'(chr_a), 8'h08);
    ppu_a12 = 1'b1;
    #1 expect_eq("chr0_hi", 8'(chr_a), 8'h09);

    // Back-to-back ROM writes: the second is dropped.
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 0);
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 0);
    gap();
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 0);
    for (int i = 0; i < 3; i++) begin
      gap();
      bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0);
    end
    gap();
    @(negedge clk); cpu_a14 = 1'b0;
    #1 expect_eq("consec_prg", 8'(prg_a), 8'h03);

    write_val(1'b0, 1'b0, 5'b10010, 0);
    write_val(1'b0, 1'b1, 3, 0);
    write_val(1'b1, 1'b0, 7, 0);
    @(negedge clk); ppu_a12 = 1'b0;
    #1 expect_eq("chr4k_lo", 8'(chr_a), 8'h03);
    ppu_a12 = 1'b1;
    #1 expect_eq("chr4k_hi", 8'(chr_a), 8'h07);
    ppu_a10 = 1'b1;
    #1 expect_eq("vert_a10_1", 8'(ciram_a10), 8'h01);
    ppu_a10 = 1'b0;
    #1 expect_eq("vert_a10_0", 8'(ciram_a10), 8'h00);
    write_val(1'b0, 1'b0, 5'b10011, 1);

    write_val(1'b1, 1'b1, 5'b10000, 0);
    wram_probe("wram_disabled", 8'h00);

    // Reset mid-sequence drops the partial shift.
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 0);
    gap();
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 0);
    gap();
    do_reset();
    write_val(1'b1, 1'b1, 5'b00110, 0);
    @(negedge clk); cpu_a14 = 1'b0;
    #1 expect_eq("post_rst_prg", 8'(prg_a), 8'h06);

    // Fifth write whose fall lands on the reset cycle must not load.
    for (int i = 0; i < 4; i++) begin
      bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 0);
      gap();
    end
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 2);
    @(negedge clk); cpu_a14 = 1'b0;
    #1 expect_eq("rst_at_fall", 8'(prg_a), 8'h00);
    write_val(1'b1, 1'b1, 5'b01001, 0);

    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = int'($urandom_range(0, 99));
      if (kind < 3) begin
        do_reset();
      end else begin
        logic rs, rw;
        if (kind < 50)      begin rs = 1'b0; rw = 1'b0; end
        else if (kind < 75) begin rs = 1'b0; rw = 1'b1; end
        else                begin rs = 1'b1; rw = 1'(kind % 2); end
        bus_cycle(rs, rw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                  int'($urandom_range(2, 6)), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
